// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: decoded instructions, ALU ops, control FSM states, flags.
// The CU_SINGLE_STEP_EN macro adds the PAUSED state used by single-step execution.
package k_and_s_pkg;

  // Encodings 16..31 are not assigned and decode as illegal.
  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_ALU,
    S_LOAD,
    S_STORE,
    S_BRANCH,
    S_HALTED
`ifdef CU_SINGLE_STEP_EN
    ,
    S_PAUSED
`endif
  } cu_state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic unsigned_overflow;
    logic signed_overflow;
  } flags_t;

  // Condition evaluation for the branch family; unsigned_overflow is reserved.
  function automatic logic branch_taken(decoded_instruction_type instr, flags_t flags);
    logic taken;
    taken = 1'b0;
    case (instr)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = flags.zero;
      I_BNZERO: taken = !flags.zero;
      I_BNEG:   taken = flags.neg;
      I_BNNEG:  taken = !flags.neg;
      I_BOV:    taken = flags.signed_overflow;
      I_BNOV:   taken = !flags.signed_overflow;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the K&S datapath: fetch, decode, execute, write-back.
// Define CU_SINGLE_STEP_EN to add the step_req input and pause after every retired instruction.
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int RD_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CU_SINGLE_STEP_EN
  input  logic                    step_req,
`endif
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output alu_op_t                 operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halted,
  output logic                    illegal_instr,
  output logic                    instr_retired
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

`ifdef CU_SINGLE_STEP_EN
  localparam cu_state_t RETIRE_STATE = S_PAUSED;
`else
  localparam cu_state_t RETIRE_STATE = S_FETCH;
`endif

  cu_state_t  state, state_next;
  logic [1:0] wait_cnt, wait_next;
  flags_t     flags;

  assign flags = '{zero: zero_op, neg: neg_op,
                   unsigned_overflow: unsigned_overflow,
                   signed_overflow: signed_overflow};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next       = state;
    wait_next        = wait_cnt;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = OP_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halted           = 1'b0;
    illegal_instr    = 1'b0;
    instr_retired    = 1'b0;

    case (state)
      S_FETCH: begin
        if (wait_cnt != LAT) begin
          wait_next = wait_cnt + 2'd1;
        end else begin
          ir_enable  = 1'b1;
          pc_enable  = 1'b1;
          wait_next  = 2'd0;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        case (decoded_instruction)
          I_NOP: begin
            instr_retired = 1'b1;
            state_next    = RETIRE_STATE;
          end
          I_ADD, I_SUB, I_AND, I_OR, I_MOVE: state_next = S_ALU;
          I_LOAD:  state_next = S_LOAD;
          I_STORE: state_next = S_STORE;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV: state_next = S_BRANCH;
          I_HALT:  state_next = S_HALTED;
          default: begin
            illegal_instr = 1'b1;
            instr_retired = 1'b1;
            state_next    = RETIRE_STATE;
          end
        endcase
      end

      S_ALU: begin
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        case (decoded_instruction)
          I_SUB: operation = OP_SUB;
          I_AND: operation = OP_AND;
          I_OR:  operation = OP_OR;
          // The datapath presents the source on both A and B, so OR passes it through.
          I_MOVE: begin
            operation        = OP_OR;
            flags_reg_enable = 1'b0;
          end
          default: operation = OP_ADD;
        endcase
        instr_retired = 1'b1;
        state_next    = RETIRE_STATE;
      end

      S_LOAD: begin
        addr_sel = 1'b1;
        if (wait_cnt != LAT) begin
          wait_next = wait_cnt + 2'd1;
        end else begin
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
          instr_retired    = 1'b1;
          wait_next        = 2'd0;
          state_next       = RETIRE_STATE;
        end
      end

      S_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        instr_retired    = 1'b1;
        state_next       = RETIRE_STATE;
      end

      S_BRANCH: begin
        if (branch_taken(decoded_instruction, flags)) begin
          pc_enable = 1'b1;
          branch    = 1'b1;
        end
        instr_retired = 1'b1;
        state_next    = RETIRE_STATE;
      end

      S_HALTED: halted = 1'b1;

`ifdef CU_SINGLE_STEP_EN
      S_PAUSED: begin
        if (step_req) state_next = S_FETCH;
      end
`endif

      default: state_next = S_FETCH;
    endcase

    // Outputs are forced quiet for the whole reset period, whatever the state register holds.
    if (rst) begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = OP_ADD;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halted           = 1'b0;
      illegal_instr    = 1'b0;
      instr_retired    = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected output sequences against
// RD_LAT=0 and RD_LAT=2 instances, randomized instruction streams plus directed corner cases.
module tb_control_unit;
  import k_and_s_pkg::*;

  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halted;
    logic       illegal_instr;
    logic       instr_retired;
  } outv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst = 1'b1;
  decoded_instruction_type decoded_instruction = I_NOP;
  logic                    zero_op = 1'b0;
  logic                    neg_op = 1'b0;
  logic                    unsigned_overflow = 1'b0;
  logic                    signed_overflow = 1'b0;
`ifdef CU_SINGLE_STEP_EN
  logic                    step_req = 1'b0;
`endif

  outv_t o0, o2;

  control_unit #(.RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
`ifdef CU_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .branch(o0.branch), .pc_enable(o0.pc_enable), .ir_enable(o0.ir_enable),
    .addr_sel(o0.addr_sel), .c_sel(o0.c_sel), .operation(o0.operation),
    .write_reg_enable(o0.write_reg_enable), .flags_reg_enable(o0.flags_reg_enable),
    .ram_write_enable(o0.ram_write_enable), .halted(o0.halted),
    .illegal_instr(o0.illegal_instr), .instr_retired(o0.instr_retired)
  );

  control_unit #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst),
`ifdef CU_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .branch(o2.branch), .pc_enable(o2.pc_enable), .ir_enable(o2.ir_enable),
    .addr_sel(o2.addr_sel), .c_sel(o2.c_sel), .operation(o2.operation),
    .write_reg_enable(o2.write_reg_enable), .flags_reg_enable(o2.flags_reg_enable),
    .ram_write_enable(o2.ram_write_enable), .halted(o2.halted),
    .illegal_instr(o2.illegal_instr), .instr_retired(o2.instr_retired)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  int    sel = 0;  // 0: RD_LAT=0 instance, 1: RD_LAT=2 instance
  outv_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic outv_t observed();
    return (sel != 0) ? o2 : o0;
  endfunction

  // Inputs are set just after the rising edge; outputs are sampled 1 ns later, mid-cycle.
  task automatic step(input string tag, input outv_t e);
    #1;
    check(tag, 32'(observed()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs for one instruction, from fetch to retirement.
  task automatic build(input logic [4:0] op, input logic [3:0] fl, input int lat);
    outv_t v;
    logic  taken;
    exp_q.delete();
    for (int i = 0; i < lat; i++) exp_q.push_back('0);
    v = '0; v.ir_enable = 1'b1; v.pc_enable = 1'b1;
    exp_q.push_back(v);
    v = '0;
    if (op == I_NOP) v.instr_retired = 1'b1;
    if (op > 5'd15) begin
      v.instr_retired = 1'b1;
      v.illegal_instr = 1'b1;
    end
    exp_q.push_back(v);
    v = '0;
    taken = 1'b0;
    case (op)
      I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
        v.write_reg_enable = 1'b1;
        v.instr_retired    = 1'b1;
        v.flags_reg_enable = (op != I_MOVE);
        v.operation = (op == I_SUB) ? 2'd1 : (op == I_AND) ? 2'd2 :
                      (op == I_OR || op == I_MOVE) ? 2'd3 : 2'd0;
        exp_q.push_back(v);
      end
      I_LOAD: begin
        v.addr_sel = 1'b1;
        for (int i = 0; i < lat; i++) exp_q.push_back(v);
        v.c_sel = 1'b1; v.write_reg_enable = 1'b1; v.instr_retired = 1'b1;
        exp_q.push_back(v);
      end
      I_STORE: begin
        v.addr_sel = 1'b1; v.ram_write_enable = 1'b1; v.instr_retired = 1'b1;
        exp_q.push_back(v);
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        case (op)
          I_BRANCH: taken = 1'b1;
          I_BZERO:  taken = fl[3];
          I_BNZERO: taken = !fl[3];
          I_BNEG:   taken = fl[2];
          I_BNNEG:  taken = !fl[2];
          I_BOV:    taken = fl[0];
          default:  taken = !fl[0];
        endcase
        v.pc_enable = taken; v.branch = taken; v.instr_retired = 1'b1;
        exp_q.push_back(v);
      end
      I_HALT: begin
        v.halted = 1'b1;
        exp_q.push_back(v);
      end
      default: ;
    endcase
  endtask

  // Runs one instruction from FETCH; checks at most n_max cycles (fewer = abort mid-way).
  task automatic run_instr(input string name, input logic [4:0] op, input logic [3:0] fl,
                           input int n_max, input int pause_len);
    int n;
    decoded_instruction = decoded_instruction_type'(op);
    {zero_op, neg_op, unsigned_overflow, signed_overflow} = fl;
    build(op, fl, (sel != 0) ? 2 : 0);
    n = (n_max < exp_q.size()) ? n_max : exp_q.size();
    for (int i = 0; i < n; i++) step($sformatf("%s op%0d c%0d", name, op, i), exp_q[i]);
`ifdef CU_SINGLE_STEP_EN
    if (n == exp_q.size() && op != I_HALT) begin
      for (int i = 0; i < pause_len; i++) step($sformatf("%s paused c%0d", name, i), '0);
      step_req = 1'b1;
      step($sformatf("%s step", name), '0);
      step_req = 1'b0;
    end
`else
    if (pause_len < 0) $display("negative pause length ignored");
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("reset c%0d", i), '0);
    rst = 1'b0;
  endtask

  task automatic random_stream(input int count);
    logic [4:0] op;
    for (int k = 0; k < count; k++) begin
      if ($urandom_range(0, 5) == 0) op = 5'($urandom_range(16, 31));
      else op = 5'($urandom_range(0, 14));  // HALT would stall the stream
      run_instr("rand", op, 4'($urandom_range(0, 15)), 99, $urandom_range(0, 3));
    end
  endtask

  initial begin
    outv_t h;
    @(posedge clk);
    #1;

    sel = 0;
    do_reset();
    run_instr("add", I_ADD, 4'b0000, 99, 1);
    run_instr("bzero_t", I_BZERO, 4'b1000, 99, 0);
    run_instr("bzero_nt", I_BZERO, 4'b0111, 99, 0);
    run_instr("move", I_MOVE, 4'b1111, 99, 0);
    run_instr("store", I_STORE, 4'b0000, 99, 10);
    random_stream(150);
    run_instr("illegal", 5'd21, 4'b0000, 99, 0);
    run_instr("halt", I_HALT, 4'b0000, 99, 0);
    h = '0; h.halted = 1'b1;
    for (int i = 0; i < 100; i++) step($sformatf("halt hold c%0d", i), h);
    do_reset();
    run_instr("after_halt", I_NOP, 4'b0000, 99, 0);

    sel = 1;
    do_reset();
    run_instr("load_abort", I_LOAD, 4'b0000, 5, 0);
    do_reset();
    run_instr("load_lat2", I_LOAD, 4'b0000, 99, 2);
    random_stream(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
